seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 71 +++++++
 tb/tb_seq_detect_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable N-bit pattern, overlapping or
// non-overlapping detection, and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned N        = 4,
  parameter logic [N-1:0] INIT_PAT = 4'b1010,
  parameter bit          OVERLAP  = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned FILL_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);

  logic [N-1:0]      r_pat;
  logic [N-2:0]      r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_y;

  logic [N-1:0]      w_cand;
  logic              w_match;
  logic              w_cnt_max;

  assign w_cand    = {r_hist, x};
  assign w_match   = en && (r_fill == FILL_MAX) && (w_cand == r_pat);
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat  <= INIT_PAT;
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_y    <= 1'b0;
    end else if (load) begin
      r_pat  <= pat_in;
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_y    <= 1'b0;
    end else if (en) begin
      r_hist <= w_cand[N-2:0];
      r_y    <= w_match;
      // Non-overlapping mode restarts the fill count so the next match needs N fresh bits
      if (w_match && !OVERLAP) begin
        r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_match && !w_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_y <= 1'b0;
    end
  end

  assign y         = r_y;
  assign match_cnt = r_cnt;
  assign cnt_sat   = w_cnt_max;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus stream; table rows plus corner sequences.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, en, x, load;
  logic [3:0] pat_in;

  logic       y_ov, y_no, y_s;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_s;
  logic       sat_ov, sat_no, sat_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.N(4), .INIT_PAT(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .y(y_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov));

  seq_detect_param #(.N(4), .INIT_PAT(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .y(y_no), .match_cnt(cnt_no), .cnt_sat(sat_no));

  seq_detect_param #(.N(4), .INIT_PAT(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .y(y_s), .match_cnt(cnt_s), .cnt_sat(sat_s));

  typedef struct {
    logic       r, e, xi, l;
    logic [3:0] p;
    logic       y_ov, y_no;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_s;
    logic       sat_s;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input logic r, input logic e, input logic xi, input logic l,
                              input logic [3:0] p, input logic yo, input logic yn,
                              input logic [7:0] co, input logic [7:0] cn,
                              input logic [1:0] cs, input logic ss);
    vec_t v;
    v.r = r; v.e = e; v.xi = xi; v.l = l; v.p = p;
    v.y_ov = yo; v.y_no = yn; v.c_ov = co; v.c_no = cn; v.c_s = cs; v.sat_s = ss;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one edge's inputs, then sample outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic xi, input logic l,
                      input logic [3:0] p);
    rst = r; en = e; x = xi; load = l; pat_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int m;
    logic [7:0] pat_bits;
    rst = 1'b0; en = 1'b0; x = 1'b0; load = 1'b0; pat_in = 4'b0000;

    //  r  e  x  l  pat      yo yn cov cno cs sat
    row(0, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    // stream 1000111010101010
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    1, 1, 1, 1, 1, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 1, 1, 1, 0);
    row(1, 1, 0, 0, 4'h0,    1, 0, 2, 1, 2, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 2, 1, 2, 0);
    row(1, 1, 0, 0, 4'h0,    1, 1, 3, 2, 3, 1);
    row(1, 1, 1, 0, 4'h0,    0, 0, 3, 2, 3, 1);
    row(1, 1, 0, 0, 4'h0,    1, 0, 4, 2, 3, 1);
    // reset overriding a load of 0000, then 1,0,1,0 with en gaps (x toggled in gaps)
    row(0, 1, 1, 1, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 4'h0,    0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0,    1, 1, 1, 1, 1, 0);
    row(1, 0, 1, 0, 4'h0,    0, 0, 1, 1, 1, 0);
    row(1, 0, 0, 0, 4'h0,    0, 0, 1, 1, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].xi, tbl[i].l, tbl[i].p);
      chk($sformatf("tbl[%0d] y_ov", i),   32'(y_ov),   32'(tbl[i].y_ov));
      chk($sformatf("tbl[%0d] y_no", i),   32'(y_no),   32'(tbl[i].y_no));
      chk($sformatf("tbl[%0d] y_s", i),    32'(y_s),    32'(tbl[i].y_ov));
      chk($sformatf("tbl[%0d] cnt_ov", i), 32'(cnt_ov), 32'(tbl[i].c_ov));
      chk($sformatf("tbl[%0d] cnt_no", i), 32'(cnt_no), 32'(tbl[i].c_no));
      chk($sformatf("tbl[%0d] cnt_s", i),  32'(cnt_s),  32'(tbl[i].c_s));
      chk($sformatf("tbl[%0d] sat_s", i),  32'(sat_s),  32'(tbl[i].sat_s));
      chk($sformatf("tbl[%0d] sat_ov", i), 32'(sat_ov), 32'd0);
    end

    // Load mid-stream: 1010 then 011 primes history, load 0111 while en=1 x=1
    step(0, 0, 0, 0, 4'h0);
    step(1, 1, 1, 0, 4'h0); step(1, 1, 0, 0, 4'h0);
    step(1, 1, 1, 0, 4'h0); step(1, 1, 0, 0, 4'h0);
    chk("load pre cnt_ov", 32'(cnt_ov), 32'd1);
    step(1, 1, 0, 0, 4'h0); step(1, 1, 1, 0, 4'h0); step(1, 1, 1, 0, 4'h0);
    step(1, 1, 1, 1, 4'b0111);
    chk("load y_ov", 32'(y_ov), 32'd0);
    chk("load cnt_ov", 32'(cnt_ov), 32'd0);
    chk("load cnt_no", 32'(cnt_no), 32'd0);
    pat_bits = 8'b0111_0111;
    for (int unsigned k = 0; k < 8; k++) begin
      step(1, 1, pat_bits[7-k], 0, 4'h0);
      chk($sformatf("load bit%0d y_ov", k), 32'(y_ov), 32'((k == 3) || (k == 7)));
      chk($sformatf("load bit%0d y_no", k), 32'(y_no), 32'((k == 3) || (k == 7)));
    end
    chk("load end cnt_ov", 32'(cnt_ov), 32'd2);
    chk("load end cnt_no", 32'(cnt_no), 32'd2);

    // Reset after 101 discards the partial pattern
    step(0, 0, 0, 0, 4'h0);
    step(1, 1, 1, 0, 4'h0); step(1, 1, 0, 0, 4'h0); step(1, 1, 1, 0, 4'h0);
    step(0, 1, 0, 0, 4'h0);
    chk("midrst y_ov", 32'(y_ov), 32'd0);
    chk("midrst cnt_ov", 32'(cnt_ov), 32'd0);
    step(1, 1, 0, 0, 4'h0);
    chk("midrst bit0 y_ov", 32'(y_ov), 32'd0);
    pat_bits = 8'b0000_1010;
    for (int unsigned k = 0; k < 4; k++) begin
      step(1, 1, pat_bits[3-k], 0, 4'h0);
      chk($sformatf("midrst tail%0d y_ov", k), 32'(y_ov), 32'(k == 3));
    end
    chk("midrst cnt_ov", 32'(cnt_ov), 32'd1);

    // Saturation of the 2-bit counter on 10101010101010
    step(0, 0, 0, 0, 4'h0);
    m = 0;
    for (int unsigned k = 1; k <= 14; k++) begin
      step(1, 1, (k % 2) == 1, 0, 4'h0);
      if (k >= 4 && (k % 2) == 0) m++;
      chk($sformatf("sat bit%0d y_s", k), 32'(y_s), 32'(k >= 4 && (k % 2) == 0));
      chk($sformatf("sat bit%0d cnt_s", k), 32'(cnt_s), 32'((m > 3) ? 3 : m));
      chk($sformatf("sat bit%0d sat_s", k), 32'(sat_s), 32'(m >= 3));
    end
    chk("sat cnt_ov", 32'(cnt_ov), 32'd6);
    chk("sat sat_ov", 32'(sat_ov), 32'd0);
    chk("sat sat_no", 32'(sat_no), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
